uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of uart_rx. It captures each byte uart_rx delivers, together with that byte's frame-error status, into a synchronous FIFO. It presents the buffered bytes to the host/core side through a valid/ready handshake. This decouples UART line timing from consumer back-pressure and records overruns.

Parameters:
SIZE, 8, data width in bits; must match uart_rx data width.
DEPTH, 16, FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  reset, synchronous active-low: reset is sampled on the rising edge of clk; 0 = reset asserted
rx_data  in  SIZE  byte from uart_rx, valid while rx_ready is high
rx_ready  in  1  uart_rx byte-available flag; level may persist for several cycles
rx_error  in  1  uart_rx frame-error flag, sampled together with rx_data
m_data  out  SIZE  head-of-FIFO byte
m_error  out  1  frame-error bit stored with the head byte
m_valid  out  1  head entry valid
m_ready  in  1  consumer accepts the head entry when m_valid && m_ready
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; set when a byte is lost because the FIFO is full
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (reset==0 at a clk edge): rd_ptr=0, wr_ptr=0, count=0, m_valid=0, m_data=0, m_error=0, overflow=0, rx_ready edge register=1.
  - The edge register resets to 1 so that a rx_ready held high through reset does not produce a spurious write.
  - Reset mid-transfer discards all stored entries.
- Write strobe:
  - wr_stb = rx_ready && !rx_ready_q, where rx_ready_q is rx_ready registered each clk.
  - Exactly one write per rx_ready rising edge, however long rx_ready stays high.
  - {rx_error, rx_data} is captured in the same cycle as wr_stb.
- Read strobe: rd_stb = m_valid && m_ready.
- First-word-fall-through:
  - m_data/m_error continuously reflect mem[rd_ptr] when count>0.
  - m_valid = (count != 0).
  - Write-to-m_valid latency: m_valid rises on the clk edge after the wr_stb cycle, i.e. 1 cycle.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is the authoritative full/empty indicator; full = (count==DEPTH).
- Simultaneous events:
  - wr_stb && rd_stb, not full, not empty: write and read both occur; count unchanged.
  - wr_stb && rd_stb && full: the read frees a slot, so the write is accepted; count stays DEPTH; no overflow.
  - wr_stb && empty: no read can occur, because m_valid=0.
  - wr_stb && full && !rd_stb: byte dropped, pointers unchanged, overflow<=1.
- Overflow:
  - Remains 1 until clr_overflow=1 at a clk edge, or reset.
  - If clr_overflow and a new drop coincide in the same cycle, set wins; overflow stays 1.
- m_ready while m_valid=0 is ignored.
- No combinational path from rx_* inputs to m_* outputs.
- count arithmetic: +1 on accepted write only, -1 on read only, otherwise unchanged. Never underflows or exceeds DEPTH.

Optional Feature:
Macro UART_RXF_DROP_ERR_EN.
- Defined:
  - A wr_stb with rx_error=1 is discarded and never stored.
  - A sticky output err_drop (1 bit, reset 0, cleared by clr_overflow) is added and set on each discard.
  - m_error is tied to 0.
  - A discarded errored byte never sets overflow, even when the FIFO is full.
- Not defined: errored bytes are stored with m_error=1; the err_drop port does not exist.

Test Plan:
- Reset, then one rx_ready pulse with rx_data=0xA5, rx_error=0 -> m_valid=1 one cycle later, m_data=0xA5, m_error=0, count=1; after one cycle of m_ready=1 -> m_valid=0, count=0.
- rx_ready held high for 20 cycles with rx_data=0x3C -> exactly one entry; count=1.
- Write 16 bytes 0x00..0x0F with m_ready=0, then a 17th byte 0xFF -> count=16, overflow=1; drain with m_ready=1 -> bytes read in order 0x00..0x0F; 0xFF is never seen.
- Full FIFO, wr_stb of 0x77 in the same cycle as a read -> count stays 16, overflow stays 0, and 0x77 is read last.
- rx_error=1 with rx_data=0xFF:
  - Macro undefined: m_error=1, m_data=0xFF.
  - Macro defined: count stays 0, err_drop=1; clr_overflow clears err_drop.
- With 5 entries stored, assert reset=0 for one cycle -> count=0, m_valid=0, overflow=0; rx_ready already high when reset releases -> no write.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundles the uart_rx-side capture signals and the host-side
// valid/ready head-of-queue signals with the status outputs.
// slave = FIFO view (rx_* in, m_* out); master = producer/consumer view.
// Optional err_drop status exists only when UART_RXF_DROP_ERR_EN is defined.
interface uart_rx_fifo_if #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 16
);
    logic [SIZE-1:0]        rx_data;
    logic                   rx_ready;
    logic                   rx_error;
    logic [SIZE-1:0]        m_data;
    logic                   m_error;
    logic                   m_valid;
    logic                   m_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   clr_overflow;
`ifdef UART_RXF_DROP_ERR_EN
    logic                   err_drop;

    modport slave (
        input  rx_data, rx_ready, rx_error, m_ready, clr_overflow,
        output m_data, m_error, m_valid, count, overflow, err_drop
    );
    modport master (
        output rx_data, rx_ready, rx_error, m_ready, clr_overflow,
        input  m_data, m_error, m_valid, count, overflow, err_drop
    );
`else
    modport slave (
        input  rx_data, rx_ready, rx_error, m_ready, clr_overflow,
        output m_data, m_error, m_valid, count, overflow
    );
    modport master (
        output rx_data, rx_ready, rx_error, m_ready, clr_overflow,
        input  m_data, m_error, m_valid, count, overflow
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose: buffers bytes (plus frame-error flag) from uart_rx into a FWFT FIFO.
// Latency: rx_ready rising edge -> m_valid high one clk later; head shown combinationally from RAM.
// Backpressure: consumer stalls via m_ready; full FIFO drops new bytes and sets sticky overflow.
//
// Ports: clk, reset (sync active-low), bus (uart_rx_fifo_if.slave): rx_data/rx_ready/rx_error
// from uart_rx; m_data/m_error/m_valid/m_ready host handshake; count, overflow, clr_overflow.
// Optional macro UART_RXF_DROP_ERR_EN: errored bytes are discarded and flagged on err_drop.
module uart_rx_fifo #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic            err;
        logic [SIZE-1:0] dat;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;
    logic            rx_ready_q;
    logic            overflow_q;
    logic            full;
    logic            wr_stb;
    logic            wr_req;
    logic            rd_stb;
    logic            wr_acc;
    logic            drop;

    assign full   = (count_q == FULL_CNT);
    // One write per rising edge of rx_ready, however long the level persists.
    assign wr_stb = bus.rx_ready && !rx_ready_q;
    assign rd_stb = (count_q != '0) && bus.m_ready;

`ifdef UART_RXF_DROP_ERR_EN
    logic err_drop_q;
    logic err_stb;
    assign err_stb      = wr_stb && bus.rx_error;
    assign wr_req       = wr_stb && !bus.rx_error;
    assign bus.err_drop = err_drop_q;
    assign bus.m_error  = 1'b0;
`else
    assign wr_req       = wr_stb;
    assign bus.m_error  = (count_q != '0) ? mem[rd_ptr].err : 1'b0;
`endif

    // A read in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign wr_acc = wr_req && (!full || rd_stb);
    assign drop   = wr_req && full && !rd_stb;

    assign bus.m_valid  = (count_q != '0);
    assign bus.m_data   = (count_q != '0) ? mem[rd_ptr].dat : '0;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

    // Storage needs no reset: contents are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= '{err: bus.rx_error, dat: bus.rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            // Held at 1 so an rx_ready already high at release is not seen as an edge.
            rx_ready_q <= 1'b1;
        end else begin
            rx_ready_q <= bus.rx_ready;
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_stb) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_stb})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Set wins over a coincident clear.
            if (drop)                  overflow_q <= 1'b1;
            else if (bus.clr_overflow) overflow_q <= 1'b0;
        end
    end

`ifdef UART_RXF_DROP_ERR_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_drop_q <= 1'b0;
        end else if (err_stb) begin
            err_drop_q <= 1'b1;
        end else if (bus.clr_overflow) begin
            err_drop_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: reset state, single byte, held rx_ready,
// overflow, full-FIFO simultaneous read/write, frame error handling, reset flush.
module tb_uart_rx_fifo;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    uart_rx_fifo_if #(.SIZE(8), .DEPTH(16)) bus ();

    uart_rx_fifo #(.SIZE(8), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rx_ready pulse of one cycle, then one idle cycle.
    task automatic write_byte(input logic [7:0] d, input logic e);
        bus.rx_data  = d;
        bus.rx_error = e;
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset            = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rx_ready     = 1'b0;
        bus.rx_error     = 1'b0;
        bus.m_ready      = 1'b0;
        bus.clr_overflow = 1'b0;
        tick();
        tick();
        chk("rst_count",    32'(bus.count),    32'd0);
        chk("rst_m_valid",  32'(bus.m_valid),  32'd0);
        chk("rst_m_data",   32'(bus.m_data),   32'h00);
        chk("rst_m_error",  32'(bus.m_error),  32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        reset = 1'b1;
        tick();

        // m_ready while empty is ignored
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("empty_rd_count", 32'(bus.count), 32'd0);

        // Single byte: m_valid one cycle after the strobe cycle
        bus.rx_data  = 8'hA5;
        bus.rx_error = 1'b0;
        bus.rx_ready = 1'b1;
        chk("pre_wr_valid", 32'(bus.m_valid), 32'd0);
        tick();
        chk("t1_valid",   32'(bus.m_valid), 32'd1);
        chk("t1_data",    32'(bus.m_data),  32'hA5);
        chk("t1_error",   32'(bus.m_error), 32'd0);
        chk("t1_count",   32'(bus.count),   32'd1);
        bus.rx_ready = 1'b0;
        tick();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("t1_rd_valid", 32'(bus.m_valid), 32'd0);
        chk("t1_rd_count", 32'(bus.count),   32'd0);

        // rx_ready held high for 20 cycles gives exactly one entry
        bus.rx_data  = 8'h3C;
        bus.rx_ready = 1'b1;
        repeat (20) tick();
        bus.rx_ready = 1'b0;
        tick();
        chk("hold_count", 32'(bus.count),  32'd1);
        chk("hold_data",  32'(bus.m_data), 32'h3C);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("hold_drain", 32'(bus.count), 32'd0);

        // Fill 16, drop 17th, drain in order
        for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b0);
        chk("fill_count", 32'(bus.count),    32'd16);
        chk("fill_ovf",   32'(bus.overflow), 32'd0);
        write_byte(8'hFF, 1'b0);
        chk("drop_count", 32'(bus.count),    32'd16);
        chk("drop_ovf",   32'(bus.overflow), 32'd1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(bus.m_data), 32'(i));
            tick();
        end
        bus.m_ready = 1'b0;
        chk("drain_valid", 32'(bus.m_valid),  32'd0);
        chk("drain_count", 32'(bus.count),    32'd0);
        chk("ovf_sticky",  32'(bus.overflow), 32'd1);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        // Full FIFO: write and read in the same cycle
        for (int i = 0; i < 16; i++) write_byte(8'(8'h10 + i), 1'b0);
        chk("full2_count", 32'(bus.count), 32'd16);
        bus.rx_data  = 8'h77;
        bus.rx_ready = 1'b1;
        bus.m_ready  = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        bus.m_ready  = 1'b0;
        tick();
        chk("simul_count", 32'(bus.count),    32'd16);
        chk("simul_ovf",   32'(bus.overflow), 32'd0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("simul_drain_%0d", i), 32'(bus.m_data), 32'(8'h11 + i));
            tick();
        end
        chk("simul_last", 32'(bus.m_data), 32'h77);
        tick();
        bus.m_ready = 1'b0;
        chk("simul_empty", 32'(bus.count), 32'd0);

        // Frame error byte
        write_byte(8'hFF, 1'b1);
`ifdef UART_RXF_DROP_ERR_EN
        chk("errdrop_count", 32'(bus.count),    32'd0);
        chk("errdrop_flag",  32'(bus.err_drop), 32'd1);
        chk("errdrop_ovf",   32'(bus.overflow), 32'd0);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        chk("errdrop_clr",   32'(bus.err_drop), 32'd0);
`else
        chk("err_valid", 32'(bus.m_valid), 32'd1);
        chk("err_data",  32'(bus.m_data),  32'hFF);
        chk("err_flag",  32'(bus.m_error), 32'd1);
        chk("err_count", 32'(bus.count),   32'd1);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("err_drain", 32'(bus.count), 32'd0);
`endif

        // Reset with 5 entries, rx_ready high across release
        for (int i = 0; i < 5; i++) write_byte(8'(8'h50 + i), 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'd5);
        bus.rx_data  = 8'h99;
        bus.rx_ready = 1'b1;
        reset = 1'b0;
        tick();
        chk("mid_rst_count", 32'(bus.count),    32'd0);
        chk("mid_rst_valid", 32'(bus.m_valid),  32'd0);
        chk("mid_rst_ovf",   32'(bus.overflow), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        chk("post_rst_count", 32'(bus.count),   32'd0);
        chk("post_rst_valid", 32'(bus.m_valid), 32'd0);
        bus.rx_ready = 1'b0;
        tick();
        write_byte(8'h42, 1'b0);
        chk("post_rst_wr_count", 32'(bus.count),  32'd1);
        chk("post_rst_wr_data",  32'(bus.m_data), 32'h42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
